// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RR-stage hazard control for a five-stage pipe.
// Resolves RAW stalls, operand forwarding, branch flush and halt drain.
// Ports: clk, resetn (active-high async reset)
//   in : rr_valid/rr_src_a/rr_src_b/rr_use_a/rr_use_b (consumer in RR)
//        ex_valid/ex_wr/ex_load/ex_dst, ma_valid/ma_wr/ma_dst,
//        wb_valid/wb_wr/wb_dst (producers), br_taken, halt_req
//   out: stall_front, bubble_ex, flush_front, fwd_a, fwd_b,
//        halt_ack, stall_cnt (saturating stall-cycle count)
// Build option: define PIPE_HAZARD_FWD_EN to enable forwarding;
//   without it every RAW match stalls and fwd_a/fwd_b stay 00.
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 3,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rr_valid,
  input  logic [REG_AW-1:0] rr_src_a,
  input  logic [REG_AW-1:0] rr_src_b,
  input  logic              rr_use_a,
  input  logic              rr_use_b,
  input  logic              ex_valid,
  input  logic              ex_wr,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ma_valid,
  input  logic              ma_wr,
  input  logic [REG_AW-1:0] ma_dst,
  input  logic              wb_valid,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              br_taken,
  input  logic              halt_req,
  output logic              halt_ack,
  output logic              stall_front,
  output logic              bubble_ex,
  output logic              flush_front,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [7:0]        stall_cnt
);

  typedef enum logic [1:0] {
    RUN,
    LDSTALL,
    FLUSH,
    HALT
  } state_t;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC - 1);
  localparam bit         FLUSH_MULTI = (FLUSH_CYC > 1);

  state_t     state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       ack_d;
  logic       stall_c, bubble_c, flush_c;
  logic       raw;
  logic [1:0] fwd_a_c, fwd_b_c;

  // Per-operand matches already include rr_valid and rr_use, so
  // forwarding selects fall back to 00 when an operand is unused.
  logic m_ex_a, m_ex_b, m_ma_a, m_ma_b, m_wb_a, m_wb_b;
  logic p_ex, p_ma, p_wb;

  assign p_ex = rr_valid & ex_valid & ex_wr;
  assign p_ma = rr_valid & ma_valid & ma_wr;
  assign p_wb = rr_valid & wb_valid & wb_wr;

  assign m_ex_a = p_ex & rr_use_a & (rr_src_a == ex_dst);
  assign m_ex_b = p_ex & rr_use_b & (rr_src_b == ex_dst);
  assign m_ma_a = p_ma & rr_use_a & (rr_src_a == ma_dst);
  assign m_ma_b = p_ma & rr_use_b & (rr_src_b == ma_dst);
  assign m_wb_a = p_wb & rr_use_a & (rr_src_a == wb_dst);
  assign m_wb_b = p_wb & rr_use_b & (rr_src_b == wb_dst);

`ifdef PIPE_HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign raw = (m_ex_a | m_ex_b) & ex_load;

  // Youngest producer wins.
  assign fwd_a_c = m_ex_a ? 2'b01 :
                   m_ma_a ? 2'b10 :
                   m_wb_a ? 2'b11 : 2'b00;
  assign fwd_b_c = m_ex_b ? 2'b01 :
                   m_ma_b ? 2'b10 :
                   m_wb_b ? 2'b11 : 2'b00;
`else
  logic unused_load;
  assign unused_load = ex_load;

  assign raw = m_ex_a | m_ex_b | m_ma_a |
               m_ma_b | m_wb_a | m_wb_b;
  assign fwd_a_c = 2'b00;
  assign fwd_b_c = 2'b00;
`endif

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    unique case (state_q)
      RUN, LDSTALL: begin
        if (br_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          fcnt_d   = FLUSH_INIT;
          state_d  = FLUSH_MULTI ? FLUSH : RUN;
        end else if (halt_req && state_q == RUN) begin
          state_d = HALT;
        end else if (raw) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = LDSTALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        fcnt_d  = fcnt_q - 2'd1;
        if (fcnt_q <= 2'd1) state_d = RUN;
      end
      HALT: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (!halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign ack_d = (state_d == HALT);

  // Reset overrides the Mealy outputs: front end is held flushed.
  assign stall_front = ~resetn & stall_c;
  assign bubble_ex   = ~resetn & bubble_c;
  assign flush_front = resetn | flush_c;
  assign fwd_a       = resetn ? 2'b00 : fwd_a_c;
  assign fwd_b       = resetn ? 2'b00 : fwd_b_c;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q   <= RUN;
      fcnt_q    <= 2'd0;
      halt_ack  <= 1'b0;
      stall_cnt <= 8'd0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      halt_ack <= ack_d;
      if (stall_c && stall_cnt != 8'hFF)
        stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule
